// File: rtl/sigdata_pkg.sv
// Shared types and constants for the sigdata_gen stimulus source.
// No logic of its own, so no latency and no backpressure.
// The FSM state enum and the step-mode encodings live here.
package sigdata_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Wide enough for the largest request-to-update wait of 255 cycles.
    localparam int CNT_W = 8;

endpackage

// File: rtl/sigdata_next.sv
// Next-value computation for sigdata_gen: fixed increment or Galois LFSR step.
// Purely combinational (zero latency).
// No backpressure; the result is consumed only on the update edge.
// Build option SIGDATA_LFSR_EN adds the mode input, the LFSR path and the LFSR_TAPS parameter.
module sigdata_next
    import sigdata_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter logic [DATA_W-1:0] STEP      = DATA_W'(1)
`ifdef SIGDATA_LFSR_EN
    ,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(4'b1001)
`endif
) (
`ifdef SIGDATA_LFSR_EN
    input  logic              mode,
`endif
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] next_data
);

`ifdef SIGDATA_LFSR_EN
    logic [DATA_W-1:0] inc_val;
    logic [DATA_W-1:0] lfsr_val;

    // Select between the increment step and a right-shifting Galois LFSR step.
    always_comb begin
        inc_val = data + STEP;
        if (data == '0) begin
            // An all-zero register would stay at zero forever; kick it to 1.
            lfsr_val = DATA_W'(1);
        end else if (data[0]) begin
            lfsr_val = (data >> 1) ^ LFSR_TAPS;
        end else begin
            lfsr_val = data >> 1;
        end
        next_data = (mode == MODE_LFSR) ? lfsr_val : inc_val;
    end
`else
    // Increment only; the sum wraps modulo 2^DATA_W.
    always_comb begin
        next_data = data + STEP;
    end
`endif

endmodule

// File: rtl/sigdata_gen.sv
// Request-driven stimulus source: a rising edge on ask_for_data advances data once after a programmable wait.
// Latency: the update and the data_valid strobe are registered DELAY+1 edges after the request edge is sampled.
// No backpressure; one further request can be held pending, and any more are dropped and flagged in sticky overrun.
// Build option SIGDATA_LFSR_EN adds the mode port and the LFSR step mode.
module sigdata_gen
    import sigdata_pkg::*;
#(
    parameter int                DATA_W    = 4,
    parameter int                DELAY     = 3,
    parameter logic [DATA_W-1:0] STEP      = DATA_W'(1),
    parameter logic [DATA_W-1:0] INIT      = '0
`ifdef SIGDATA_LFSR_EN
    ,
    parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(4'b1001)
`endif
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              ask_for_data,
`ifdef SIGDATA_LFSR_EN
    input  logic              mode,
`endif
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              busy,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DELAY);

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic              pending;
    logic              pending_nx;
    logic              overrun_nx;
    logic              valid_nx;
    logic [DATA_W-1:0] data_nx;
    logic [DATA_W-1:0] next_val;
    logic              ask_q;
    logic              req_edge;

    // ask_q resets high, so a request level already high at reset release is not an edge.
    assign req_edge = ask_for_data & ~ask_q;

    sigdata_next #(
        .DATA_W    (DATA_W),
        .STEP      (STEP)
`ifdef SIGDATA_LFSR_EN
        ,
        .LFSR_TAPS (LFSR_TAPS)
`endif
    ) u_next (
`ifdef SIGDATA_LFSR_EN
        .mode      (mode),
`endif
        .data      (data),
        .next_data (next_val)
    );

    // Next-state logic: request acceptance, the wait countdown, the update, and the pending and overrun bookkeeping.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        pending_nx = pending;
        overrun_nx = overrun;
        data_nx    = data;
        valid_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_edge) begin
                    state_nx = WAIT;
                    cnt_nx   = DELAY_CNT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CNT_W'(1);
                    if (req_edge) begin
                        if (pending) begin
                            overrun_nx = 1'b1;
                        end else begin
                            pending_nx = 1'b1;
                        end
                    end
                end else begin
                    data_nx  = next_val;
                    valid_nx = 1'b1;
                    if (pending) begin
                        // Start serving the held request; a coinciding edge finds the slot still full.
                        cnt_nx     = DELAY_CNT;
                        pending_nx = 1'b0;
                        if (req_edge) begin
                            overrun_nx = 1'b1;
                        end
                    end else if (req_edge) begin
                        // A coinciding edge is latched and served right away, so it is never lost.
                        cnt_nx = DELAY_CNT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers; the active-low reset is sampled on the clock edge.
    always_ff @(posedge sclk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            pending    <= 1'b0;
            overrun    <= 1'b0;
            data       <= INIT;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            ask_q      <= 1'b1;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            pending    <= pending_nx;
            overrun    <= overrun_nx;
            data       <= data_nx;
            data_valid <= valid_nx;
            busy       <= (state_nx == WAIT);
            ask_q      <= ask_for_data;
        end
    end

endmodule
